// File: rtl/esc_diff_receiver.sv
// rtl/esc_diff_receiver.sv - escalation receiver: decodes the esc pair, answers on the resp pair, raises esc_req
// Optional ping timeout makes the receiver escalate on its own if the sender goes silent.
module esc_diff_receiver #(
  parameter int unsigned PingTimeoutCyc = 0,
  parameter int unsigned CntDw          = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic esc_p_i,
  input  logic esc_n_i,
  output logic resp_p_o,
  output logic resp_n_o,
  output logic esc_req_o,
  output logic sigint_o,
  output logic ping_timeout_o
);

  // Sparse codes, pairwise Hamming distance >= 3, so a single upset never lands on a legal state.
  typedef enum logic [4:0] {
    IdleSt    = 5'b00000,
    CheckSt   = 5'b00111,
    EscRespSt = 5'b11001,
    SigIntSt  = 5'b11110
  } state_e;

  localparam logic [CntDw-1:0] CntMax    = CntDw'(PingTimeoutCyc);
  localparam bit               TimeoutEn = (PingTimeoutCyc != 0);

  state_e           state_q, state_d;
  logic             resp_p_d, resp_n_d, esc_req_d, sigint_d;
  logic             esc_level, esc_sigint;
  logic             ping_done, cnt_active, timeout_hit;
  logic [CntDw-1:0] cnt_q, cnt_d;

  assign esc_level  = esc_p_i & ~esc_n_i;
  assign esc_sigint = (esc_p_i == esc_n_i);

  always_comb begin
    state_d   = state_q;
    resp_p_d  = 1'b0;
    resp_n_d  = 1'b1;
    esc_req_d = 1'b0;
    sigint_d  = 1'b0;
    if (esc_sigint) begin
      // Equal rails on the response pair tell the sender its pair is broken.
      state_d   = SigIntSt;
      resp_p_d  = ~resp_p_o;
      resp_n_d  = ~resp_p_o;
      esc_req_d = 1'b1;
      sigint_d  = 1'b1;
    end else begin
      case (state_q)
        IdleSt: begin
          if (esc_level) begin
            state_d  = CheckSt;
            resp_p_d = 1'b1;
            resp_n_d = 1'b0;
          end
        end
        CheckSt: begin
          if (esc_level) begin
            state_d   = EscRespSt;
            esc_req_d = 1'b1;
          end else begin
            state_d = IdleSt;
          end
        end
        EscRespSt, SigIntSt: begin
          if (esc_level) begin
            state_d   = EscRespSt;
            resp_p_d  = ~resp_p_o;
            resp_n_d  = resp_p_o;
            esc_req_d = 1'b1;
          end else begin
            state_d = IdleSt;
          end
        end
        default: begin
          state_d   = SigIntSt;
          resp_p_d  = ~resp_p_o;
          resp_n_d  = ~resp_p_o;
          esc_req_d = 1'b1;
          sigint_d  = 1'b1;
        end
      endcase
    end
  end

  // A ping finishing on the terminal count wins over the timeout.
  assign ping_done   = (state_q == CheckSt) && !esc_level && !esc_sigint;
  assign cnt_active  = TimeoutEn && ((state_q == IdleSt) || (state_q == CheckSt));
  assign timeout_hit = TimeoutEn && (cnt_q == CntMax) && !ping_done;

  always_comb begin
    cnt_d = cnt_q;
    if (!cnt_active || ping_done) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntDw'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IdleSt;
      resp_p_o       <= 1'b0;
      resp_n_o       <= 1'b1;
      esc_req_o      <= 1'b0;
      sigint_o       <= 1'b0;
      ping_timeout_o <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      resp_p_o       <= resp_p_d;
      resp_n_o       <= resp_n_d;
      esc_req_o      <= esc_req_d | ping_timeout_o | timeout_hit;
      sigint_o       <= sigint_d;
      ping_timeout_o <= ping_timeout_o | timeout_hit;
      cnt_q          <= cnt_d;
    end
  end

endmodule

// File: doc/esc_diff_receiver.md
ESC_DIFF_RECEIVER -- requirements
Module: esc_diff_receiver

Interface
REQ-001 Parameter: PingTimeoutCyc, default 0, cycles without a completed ping before self-escalation; 0 = ping timeout disabled.
REQ-002 Parameter: CntDw, default 24, ping-timeout counter width; PingTimeoutCyc SHALL fit in CntDw bits.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 esc_p_i  input  1  escalation differential pair, positive rail.
REQ-006 esc_n_i  input  1  escalation differential pair, negative rail.
REQ-007 resp_p_o  output  1  response differential pair, positive rail, registered.
REQ-008 resp_n_o  output  1  response differential pair, negative rail, registered.
REQ-009 esc_req_o  output  1  escalation action request to the local countermeasure, registered.
REQ-010 sigint_o  output  1  signal-integrity error on esc pair, registered, high while in SigIntSt.
REQ-011 ping_timeout_o  output  1  sticky flag, ping timeout expired, registered.

Function
REQ-012 Decode: esc_level = esc_p_i & ~esc_n_i; esc_sigint = (esc_p_i == esc_n_i); both combinational from sampled inputs.
REQ-013 FSM states: IdleSt, CheckSt, EscRespSt, SigIntSt; encoding SHALL use 5-bit sparse codes with pairwise Hamming distance >= 3; any other code SHALL transition to SigIntSt.
REQ-014 IdleSt: next resp = (p=0,n=1), esc_req=0; esc_level -> CheckSt with next resp = (1,0).
REQ-015 CheckSt: esc_level -> EscRespSt with next resp = (0,1) and next esc_req=1; else -> IdleSt with next resp = (0,1) (ping complete).
REQ-016 EscRespSt: esc_level -> stay, next resp_p = ~resp_p_o, next resp_n = ~next resp_p, esc_req held 1; else -> IdleSt, resp = (0,1), esc_req=0.
REQ-017 Result: single-cycle esc pulse (ping) -> resp sequence (1,0),(0,1); esc held N>=2 cycles -> esc_req_o high from 2nd cycle after first high sample until 1 cycle after esc drops, resp toggling throughout.
REQ-018 esc_sigint in any state SHALL take priority: -> SigIntSt, next resp_p = ~resp_p_o, next resp_n = next resp_p (equal rails signal error back to sender), next esc_req=1, next sigint=1.
REQ-019 SigIntSt: esc_sigint persists -> stay, both rails toggle together each cycle; esc_level -> EscRespSt (esc_req stays 1); esc idle (p=0,n=1) -> IdleSt, resp=(0,1), esc_req=0, sigint=0.
REQ-020 Ping counter: increments each cycle in IdleSt/CheckSt when PingTimeoutCyc != 0; cleared to 0 on every CheckSt->IdleSt ping completion and in EscRespSt/SigIntSt; saturates at PingTimeoutCyc, never wraps.
REQ-021 Counter == PingTimeoutCyc -> ping_timeout_o set next cycle and held until reset; while set, esc_req_o SHALL be 1 regardless of FSM state; FSM and response signalling continue normally.
REQ-022 Ping completion in the same cycle the counter reaches PingTimeoutCyc: completion wins, counter clears, no timeout.
REQ-023 esc_req_o SHALL be glitch-free (flop output, no combinational path from inputs).

Reset
REQ-024 rst_i high at a clock edge: state=IdleSt, resp_p_o=0, resp_n_o=1, esc_req_o=0, sigint_o=0, ping_timeout_o=0, counter=0; reset mid-escalation SHALL abort escalation at that edge.
REQ-025 Reset SHALL clear ping_timeout_o; no other event clears it.
REQ-026 Outputs valid first cycle after rst_i deasserted; no input sampled during reset affects state.

Verification
REQ-027 Ping: esc=(1,0) one cycle, then (0,1) -> resp (1,0) then (0,1); esc_req_o stays 0; counter cleared.
REQ-028 Escalation: esc=(1,0) for 5 cycles -> esc_req_o=1 from cycle 2 to cycle 5 inclusive, resp_p alternates 0,1,0,1 with resp_n = ~resp_p; esc_req_o=0 cycle after release.
REQ-029 Sigint: esc=(1,1) 3 cycles from IdleSt -> sigint_o=1, esc_req_o=1, resp_p==resp_n toggling; esc=(0,1) -> IdleSt, outputs (0,1),0,0.
REQ-030 Timeout: PingTimeoutCyc=10, no ping -> ping_timeout_o and esc_req_o rise after 10 counted cycles, stay high through subsequent pings until rst_i.
REQ-031 Boundary: PingTimeoutCyc=10, ping completing exactly at count 10 -> no timeout; PingTimeoutCyc=0 -> never timeout over 1000 cycles.
REQ-032 Reset mid-escalation: rst_i asserted during EscRespSt -> next cycle resp=(0,1), esc_req_o=0, state IdleSt.
